text_column_sequencer: RTL and testbench

- Sequences the 8x8 glyph renderer (drCh/chr/charDone handshake) so it draws a string of up to MAX_CHARS glyph codes once per frame.
- Glyphs are stacked in a vertical column at (ORIGIN_X, ORIGIN_Y + i*ROW_PITCH).
- Holds the string in a small write-port buffer, issues one draw request per slot, and waits for charDone before advancing.
- Sits between the video timing counters and the renderer, in the HDMI test pattern path.

---
 rtl/txt_pkg.sv | 16 +
 rtl/glyph_string_buf.sv | 31 +++
 rtl/text_column_sequencer.sv | 140 ++++++++++++++
 tb/tb_text_column_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/txt_pkg.sv
// Shared types and constants for the text column sequencer and its glyph buffer.
package txt_pkg;

  localparam int              CODE_W     = 6;
  localparam logic [CODE_W-1:0] BLANK_CODE = 6'h00;
  localparam int              GLYPH_W    = 8;
  localparam int              GLYPH_H    = 8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SLOT,
    DRAW,
    ADVANCE
  } seq_state_t;

endpackage

// File: rtl/glyph_string_buf.sv
// String buffer: MAX_CHARS glyph codes, synchronous write, combinational read.
module glyph_string_buf
  import txt_pkg::*;
#(
  parameter int MAX_CHARS = 16
) (
  input  logic                         pixclk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [$clog2(MAX_CHARS)-1:0] wr_addr,
  input  logic [CODE_W-1:0]            wr_data,
  input  logic [$clog2(MAX_CHARS)-1:0] rd_addr,
  output logic [CODE_W-1:0]            rd_data
);

  logic [CODE_W-1:0] mem [MAX_CHARS];

  // NOTE: this array is built from flops, not a RAM macro, so it can and must
  // be cleared by reset; a RAM-inferred buffer could not be reset this way.
  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_CHARS; i++) mem[i] <= BLANK_CODE;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // A same-cycle write to rd_addr is only visible from the next cycle.
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/text_column_sequencer.sv
// Issues one drCh/chr request per buffered glyph per frame, stacking glyphs
// in a column and waiting for the renderer's charDone between requests.
module text_column_sequencer
  import txt_pkg::*;
#(
  parameter int         MAX_CHARS = 16,
  parameter logic [9:0] ORIGIN_X  = 10'd64,
  parameter logic [9:0] ORIGIN_Y  = 10'd32,
  parameter logic [9:0] ROW_PITCH = 10'd10
) (
  input  logic                         pixclk,
  input  logic                         rst_n,
  input  logic [9:0]                   CounterX,
  input  logic [9:0]                   CounterY,
  input  logic                         enable,
  input  logic [$clog2(MAX_CHARS):0]   str_len,
  input  logic                         wr_en,
  input  logic [$clog2(MAX_CHARS)-1:0] wr_addr,
  input  logic [CODE_W-1:0]            wr_data,
  input  logic                         charDone,
  input  logic                         err_clr,
  output logic                         drCh,
  output logic [CODE_W-1:0]            chr,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         err_timeout
);

  localparam int AW = $clog2(MAX_CHARS);
  localparam int LW = AW + 1;

  seq_state_t        state;
  logic [AW-1:0]     idx;
  logic [LW-1:0]     len_q;
  logic [9:0]        slot_y;
  logic              charDone_q;
  logic [CODE_W-1:0] rd_data;

  logic              frame_start;
  logic              done_edge;
  logic              issue_now;
  logic              last_slot;
  logic [LW-1:0]     len_new;
  logic [10:0]       next_y;

  glyph_string_buf #(
    .MAX_CHARS(MAX_CHARS)
  ) u_buf (
    .pixclk (pixclk),
    .rst_n  (rst_n),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_addr(idx),
    .rd_data(rd_data)
  );

  always_comb begin
    frame_start = (CounterX == 10'd0) && (CounterY == 10'd0);
    len_new     = (str_len > LW'(MAX_CHARS)) ? LW'(MAX_CHARS) : str_len;
    done_edge   = charDone & ~charDone_q;
    // 11-bit sum: bit 10 flags a column that runs off the bottom of the raster.
    next_y      = {1'b0, slot_y} + {1'b0, ROW_PITCH};
    // Registering one pixel early puts drCh high exactly at CounterX==ORIGIN_X.
    issue_now   = (CounterX == ORIGIN_X - 10'd1) && (CounterY == slot_y);
    last_slot   = ({1'b0, idx} == len_q - LW'(1)) || next_y[10];
  end

  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      len_q       <= '0;
      slot_y      <= '0;
      charDone_q  <= 1'b0;
      drCh        <= 1'b0;
      chr         <= BLANK_CODE;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      charDone_q <= charDone;
      // NOTE: strobes default low here and are overridden further down; with
      // non-blocking assignments the last write in the block wins, which is
      // also how a timeout set beats a same-cycle err_clr.
      drCh       <= 1'b0;
      frame_done <= 1'b0;
      if (err_clr) err_timeout <= 1'b0;

      if (frame_start) begin
        // A frame start always restarts the string, aborting any draw in flight.
        len_q  <= len_new;
        idx    <= '0;
        slot_y <= ORIGIN_Y;
        if (enable && (len_new != '0)) begin
          busy  <= 1'b1;
          state <= WAIT_SLOT;
        end else begin
          busy       <= 1'b0;
          frame_done <= enable;
          state      <= IDLE;
        end
      end else begin
        unique case (state)
          IDLE: state <= IDLE;
          WAIT_SLOT: begin
            if (rd_data == BLANK_CODE) begin
              state <= ADVANCE;
            end else if (issue_now) begin
              drCh  <= 1'b1;
              chr   <= rd_data;
              state <= DRAW;
            end
          end
          DRAW: begin
            if (done_edge) begin
              state <= ADVANCE;
            end else if (!next_y[10] && (CounterY == next_y[9:0])) begin
              err_timeout <= 1'b1;
              state       <= ADVANCE;
            end
          end
          ADVANCE: begin
            idx    <= idx + AW'(1);
            slot_y <= next_y[9:0];
            if (last_slot) begin
              busy       <= 1'b0;
              frame_done <= 1'b1;
              state      <= IDLE;
            end else begin
              state <= WAIT_SLOT;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_text_column_sequencer.sv
// Bench for text_column_sequencer: small raster, renderer stand-in, slot-level
// model of where draws must appear, plus directed literal checks.
module tb_text_column_sequencer;
  import txt_pkg::*;

  localparam int MAX_CHARS = 16;
  localparam int H_TOTAL   = 72;
  localparam int X0        = 64;
  localparam int Y0        = 32;
  localparam int PITCH     = 10;

  logic        pixclk = 1'b0;
  logic        rst_n  = 1'b0;
  logic [9:0]  CounterX, CounterY;
  logic        enable;
  logic [4:0]  str_len;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [5:0]  wr_data;
  logic        charDone;
  logic        err_clr;
  logic        drCh;
  logic [5:0]  chr;
  logic        busy, frame_done, err_timeout;

  int checks   = 0;
  int failures = 0;
  int v_total  = 70;
  bit tie_low  = 1'b0;
  int rend_cnt = 0;

  text_column_sequencer dut (
    .pixclk     (pixclk),
    .rst_n      (rst_n),
    .CounterX   (CounterX),
    .CounterY   (CounterY),
    .enable     (enable),
    .str_len    (str_len),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .charDone   (charDone),
    .err_clr    (err_clr),
    .drCh       (drCh),
    .chr        (chr),
    .busy       (busy),
    .frame_done (frame_done),
    .err_timeout(err_timeout)
  );

  always #5 pixclk = ~pixclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at X=%0d Y=%0d", name, act, exp, CounterX, CounterY);
    end
  endtask

  // Raster: H_TOTAL pixels per line, v_total lines per frame.
  initial begin
    CounterX = 10'd0;
    CounterY = 10'd60;
    forever begin
      @(posedge pixclk); #1;
      if (CounterX == 10'(H_TOTAL - 1)) begin
        CounterX = 10'd0;
        CounterY = (int'(CounterY) >= v_total - 1) ? 10'd0 : CounterY + 10'd1;
      end else begin
        CounterX = CounterX + 10'd1;
      end
    end
  end

  // Renderer stand-in: charDone high for two cycles, 19-20 cycles after drCh.
  initial begin
    charDone = 1'b0;
    forever begin
      @(posedge pixclk); #1;
      if (drCh && !tie_low) rend_cnt = 20;
      else if (rend_cnt > 0) rend_cnt--;
      charDone = (rend_cnt == 1) || (rend_cnt == 2);
    end
  end

  // Model: a draw of buffer slot i is due at (X0, Y0+i*PITCH) whenever the
  // frame is enabled, i < min(str_len,16) and the slot holds a non-blank code
  // when its issue pixel is reached; one frame_done per enabled frame.
  logic [5:0] mbuf [MAX_CHARS];
  bit         m_started = 1'b0;
  bit         m_active  = 1'b0;
  bit         pend_drch = 1'b0;
  logic [5:0] pend_chr  = BLANK_CODE;
  int         m_len     = 0;
  int         m_fd_exp  = 0;
  int         fd_seen   = 0;
  int         m_slot    = 0;

  always @(negedge pixclk) begin
    if (!rst_n) begin
      foreach (mbuf[i]) mbuf[i] = BLANK_CODE;
      m_active  = 1'b0;
      m_fd_exp  = 0;
      fd_seen   = 0;
      pend_drch = 1'b0;
    end else begin
      check("drCh", drCh, pend_drch);
      if (pend_drch) check("chr", chr, pend_chr);
      if (frame_done) fd_seen++;
      if (CounterX == 10'd0 && CounterY == 10'd0) begin
        if (m_started) check("frame_done_count", fd_seen, m_fd_exp);
        m_started = 1'b1;
        fd_seen   = 0;
        m_len     = (int'(str_len) > MAX_CHARS) ? MAX_CHARS : int'(str_len);
        m_active  = enable && (m_len > 0);
        m_fd_exp  = enable ? 1 : 0;
      end
      pend_drch = 1'b0;
      if (m_active && int'(CounterX) == X0 - 1 && int'(CounterY) >= Y0 &&
          (int'(CounterY) - Y0) % PITCH == 0) begin
        m_slot = (int'(CounterY) - Y0) / PITCH;
        if (m_slot < m_len && mbuf[m_slot] != BLANK_CODE) begin
          pend_drch = 1'b1;
          pend_chr  = mbuf[m_slot];
        end
      end
      if (wr_en) mbuf[wr_addr] = wr_data;
    end
  end

  task automatic at_pos();
    @(posedge pixclk); #1;
  endtask

  task automatic write_buf(input int a, input logic [5:0] d);
    at_pos();
    wr_en = 1'b1; wr_addr = 4'(a); wr_data = d;
    at_pos();
    wr_en = 1'b0;
  endtask

  task automatic wait_xy(input int x, input int y);
    int n;
    n = 0;
    do begin
      @(negedge pixclk);
      n++;
      if (n > 20000) begin
        failures++;
        $display("FAIL wait_xy: raster never reached X=%0d Y=%0d", x, y);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "raster stalled");
      end
    end while (!(int'(CounterX) == x && int'(CounterY) == y));
  endtask

  initial begin
    enable = 1'b0; str_len = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; err_clr = 1'b0;

    repeat (3) @(negedge pixclk);
    check("rst_drCh", drCh, 1'b0);
    check("rst_chr", chr, BLANK_CODE);
    check("rst_busy", busy, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_err", err_timeout, 1'b0);
    #2 rst_n = 1'b1;

    // Three glyphs in a column.
    write_buf(0, 6'h1B); write_buf(1, 6'h1C); write_buf(2, 6'h1D);
    at_pos(); str_len = 5'd3; enable = 1'b1;
    wait_xy(0, 0);
    wait_xy(64, 32); check("a_drch0", drCh, 1'b1); check("a_chr0", chr, 6'h1B);
    wait_xy(40, 35); check("a_busy", busy, 1'b1);
    wait_xy(64, 42); check("a_drch1", drCh, 1'b1); check("a_chr1", chr, 6'h1C);
    wait_xy(64, 52); check("a_drch2", drCh, 1'b1); check("a_chr2", chr, 6'h1D);
    wait_xy(0, 69);  check("a_busy_end", busy, 1'b0); check("a_err", err_timeout, 1'b0);

    // Blank middle slot is skipped.
    write_buf(1, BLANK_CODE);
    wait_xy(0, 0);
    wait_xy(64, 42); check("b_skip1", drCh, 1'b0);
    wait_xy(64, 52); check("b_drch2", drCh, 1'b1); check("b_chr2", chr, 6'h1D);
    wait_xy(0, 65);
    write_buf(1, 6'h1C);
    at_pos(); tie_low = 1'b1;

    // Renderer never answers: timeouts, but every slot is still issued.
    wait_xy(0, 0);
    wait_xy(0, 41);  check("c_err_before", err_timeout, 1'b0);
    wait_xy(10, 42); check("c_err_set", err_timeout, 1'b1);
    wait_xy(64, 52); check("c_drch2", drCh, 1'b1); check("c_chr2", chr, 6'h1D);
    wait_xy(0, 69);
    at_pos(); err_clr = 1'b1;
    at_pos(); err_clr = 1'b0;
    check("c_err_clr", err_timeout, 1'b0);
    tie_low = 1'b0; str_len = 5'd0;

    // Empty string: only a frame_done pulse.
    wait_xy(0, 0);
    wait_xy(1, 0); check("d_fd_pulse", frame_done, 1'b1);
    wait_xy(2, 0); check("d_fd_low", frame_done, 1'b0); check("d_busy", busy, 1'b0);
    for (int i = 0; i < MAX_CHARS; i++) write_buf(i, 6'(6'h10 + i));
    at_pos(); str_len = 5'd20;

    // Oversized length clamps to the full 16-slot buffer.
    wait_xy(0, 0);
    at_pos(); v_total = 200;
    wait_xy(64, 182); check("e_drch15", drCh, 1'b1); check("e_chr15", chr, 6'h1F);
    wait_xy(0, 190);
    at_pos(); v_total = 70; str_len = 5'd3;

    // Reset while slot 1 is drawing.
    wait_xy(0, 0);
    wait_xy(70, 42); check("f_busy", busy, 1'b1); check("f_chr", chr, 6'h11);
    #2 rst_n = 1'b0;
    #1;
    check("f_rst_drCh", drCh, 1'b0);
    check("f_rst_chr", chr, BLANK_CODE);
    check("f_rst_busy", busy, 1'b0);
    check("f_rst_fd", frame_done, 1'b0);
    check("f_rst_err", err_timeout, 1'b0);
    @(negedge pixclk); #2 rst_n = 1'b1;

    // Buffer was cleared: an enabled frame draws nothing.
    wait_xy(0, 0);
    wait_xy(64, 32); check("g_no_draw", drCh, 1'b0); check("g_busy", busy, 1'b0);
    wait_xy(0, 65);
    write_buf(0, 6'h1B); write_buf(1, 6'h2A); write_buf(2, 6'h2B);

    // Late write to slot 2 while slot 1 draws lands in this frame.
    wait_xy(0, 0);
    wait_xy(64, 42); check("h_chr1", chr, 6'h2A);
    wait_xy(70, 42);
    write_buf(2, 6'h1C);
    wait_xy(64, 52); check("h_drch2", drCh, 1'b1); check("h_chr2", chr, 6'h1C);
    wait_xy(0, 0);
    wait_xy(5, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
